// File: rtl/instruction_loader_if.sv
// Byte-in / word-write bus of the instruction loader.
// rx side: i_rx_valid is a one-cycle strobe with no ready; a byte counts when the strobe is high at the clock edge.
// Memory side: o_we is a one-cycle write with no ready; the memory always accepts it.
interface instruction_loader_if #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
);
  logic               i_start;
  logic [7:0]         i_rx_data;
  logic               i_rx_valid;
  logic               o_we;
  logic [NB_ADDR-1:0] o_addr;
  logic [NB_DATA-1:0] o_instr_data;
  logic               o_busy;
  logic               o_done;
  logic               o_overflow;
  logic [NB_ADDR:0]   o_word_count;
  logic [1:0]         dbg_state;

  modport master (
    input  i_start, i_rx_data, i_rx_valid,
    output o_we, o_addr, o_instr_data, o_busy, o_done, o_overflow, o_word_count, dbg_state
  );

  modport slave (
    output i_start, i_rx_data, i_rx_valid,
    input  o_we, o_addr, o_instr_data, o_busy, o_done, o_overflow, o_word_count, dbg_state
  );
endinterface

// File: rtl/instruction_loader.sv
// Packs an MSB-first byte stream into instruction words and writes them to
// consecutive memory addresses until the halt word arrives or memory is full.
module instruction_loader #(
  parameter int                 NB_DATA    = 32,
  parameter int                 NB_ADDR    = 8,
  parameter int                 ADDR_STEP  = 4,
  parameter logic [NB_DATA-1:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input logic                  clk,
  input logic                  i_rst_n,
  instruction_loader_if.master bus
);
  localparam int NB_BYTES = NB_DATA / 8;
  localparam int CW       = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam int AW1      = NB_ADDR + 1;
  localparam logic [CW-1:0]  LAST_BYTE = CW'(NB_BYTES - 1);
  localparam logic [AW1-1:0] ADDR_MAX  = {1'b0, {NB_ADDR{1'b1}}};
  localparam logic [AW1-1:0] STEP_W    = AW1'(ADDR_STEP);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t             state, state_n;
  logic [CW-1:0]      byte_cnt, byte_cnt_n;
  logic [NB_DATA-9:0] word, word_n;        // bytes collected so far; the last byte completes the word
  logic [NB_ADDR-1:0] next_addr, next_addr_n;
  logic [NB_ADDR-1:0] addr, addr_n;
  logic [NB_DATA-1:0] data, data_n;
  logic [NB_ADDR:0]   count, count_n;
  logic               ovf, ovf_n;
  logic               we_q, busy_q, done_q;
  logic [NB_DATA-1:0] shifted;
  logic [AW1-1:0]     addr_inc;

  assign shifted  = {word, bus.i_rx_data};
  assign addr_inc = {1'b0, addr} + STEP_W;

  always_comb begin
    state_n     = state;
    byte_cnt_n  = byte_cnt;
    word_n      = word;
    next_addr_n = next_addr;
    addr_n      = addr;
    data_n      = data;
    count_n     = count;
    ovf_n       = ovf;
    unique case (state)
      IDLE, DONE: begin
        if (bus.i_start) begin
          state_n     = RECV;
          byte_cnt_n  = '0;
          next_addr_n = '0;
          addr_n      = '0;
          count_n     = '0;
          ovf_n       = 1'b0;
        end
      end
      RECV: begin
        if (bus.i_rx_valid) begin
          word_n     = shifted[NB_DATA-9:0];
          byte_cnt_n = byte_cnt + 1'b1;
          if (byte_cnt == LAST_BYTE) begin
            state_n    = WRITE;
            byte_cnt_n = '0;
            data_n     = shifted;
            addr_n     = next_addr;
          end
        end
      end
      WRITE: begin
        count_n = count + 1'b1;
        if (data == HALT_INSTR) begin
          state_n = DONE;
          ovf_n   = 1'b0;
        end else if (addr_inc > ADDR_MAX) begin
          state_n = DONE;
          ovf_n   = 1'b1;
        end else begin
          // A byte landing in this cycle already belongs to the next word.
          state_n     = RECV;
          next_addr_n = addr_inc[NB_ADDR-1:0];
          byte_cnt_n  = '0;
          if (bus.i_rx_valid) begin
            word_n     = shifted[NB_DATA-9:0];
            byte_cnt_n = CW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      word      <= '0;
      next_addr <= '0;
      addr      <= '0;
      data      <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      byte_cnt  <= byte_cnt_n;
      word      <= word_n;
      next_addr <= next_addr_n;
      addr      <= addr_n;
      data      <= data_n;
      count     <= count_n;
      ovf       <= ovf_n;
      we_q      <= (state_n == WRITE);
      busy_q    <= (state_n == RECV) || (state_n == WRITE);
      done_q    <= (state_n == DONE);
    end
  end

  assign bus.o_we         = we_q;
  assign bus.o_addr       = addr;
  assign bus.o_instr_data = data;
  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
  assign bus.o_overflow   = ovf;
  assign bus.o_word_count = count;
  assign bus.dbg_state    = state;
endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: a default-size loader and a 4-bit-address loader
// driven by directed and random byte streams, checked against a word-level model.
module tb_instruction_loader;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instruction_loader_if #(.NB_DATA(32), .NB_ADDR(8)) ia ();
  instruction_loader_if #(.NB_DATA(32), .NB_ADDR(4)) ib ();

  instruction_loader #(.NB_DATA(32), .NB_ADDR(8), .ADDR_STEP(4), .HALT_INSTR(HALT)) dut_a (
    .clk(clk), .i_rst_n(rst_n), .bus(ia)
  );
  instruction_loader #(.NB_DATA(32), .NB_ADDR(4), .ADDR_STEP(4), .HALT_INSTR(HALT)) dut_b (
    .clk(clk), .i_rst_n(rst_n), .bus(ib)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  logic [39:0] exp_qa[$];
  logic [39:0] exp_qb[$];
  bit          m_active[2];
  bit          m_done[2];
  bit          m_ovf[2];
  int          m_cnt[2];
  int          m_nb[2];
  logic [31:0] m_word[2];
  int          m_max[2] = '{255, 15};

  task automatic model_reset(input int id);
    m_active[id] = 0; m_done[id] = 0; m_ovf[id] = 0;
    m_cnt[id] = 0; m_nb[id] = 0; m_word[id] = '0;
  endtask

  task automatic model_start(input int id);
    if (!m_active[id]) begin
      m_active[id] = 1; m_done[id] = 0; m_ovf[id] = 0;
      m_cnt[id] = 0; m_nb[id] = 0;
    end
  endtask

  task automatic model_byte(input int id, input logic [7:0] b);
    logic [39:0] e;
    if (m_active[id]) begin
      m_word[id] = m_word[id] * 256 + 32'(b);
      m_nb[id]++;
      if (m_nb[id] == 4) begin
        e = {8'(m_cnt[id] * 4), m_word[id]};
        if (id == 0) exp_qa.push_back(e); else exp_qb.push_back(e);
        m_cnt[id]++;
        m_nb[id] = 0;
        if (m_word[id] == HALT) begin
          m_active[id] = 0; m_done[id] = 1; m_ovf[id] = 0;
        end else if (m_cnt[id] * 4 > m_max[id]) begin
          m_active[id] = 0; m_done[id] = 1; m_ovf[id] = 1;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write strobe must match the next expected word
  always @(negedge clk) begin
    logic [39:0] e;
    if (ia.o_we === 1'b1) begin
      if (exp_qa.size() == 0) check("a_unexpected_we", 64'd1, 64'd0);
      else begin
        e = exp_qa.pop_front();
        check("a_wr_addr", 64'(ia.o_addr), 64'(e[39:32]));
        check("a_wr_data", 64'(ia.o_instr_data), 64'(e[31:0]));
      end
    end
    if (ib.o_we === 1'b1) begin
      if (exp_qb.size() == 0) check("b_unexpected_we", 64'd1, 64'd0);
      else begin
        e = exp_qb.pop_front();
        check("b_wr_addr", 64'(ib.o_addr), 64'(e[39:32]));
        check("b_wr_data", 64'(ib.o_instr_data), 64'(e[31:0]));
      end
    end
  end

  task automatic check_status(input int id, input string tag);
    if (id == 0) begin
      check({tag, "_done"}, 64'(ia.o_done), 64'(m_done[0]));
      check({tag, "_ovf"}, 64'(ia.o_overflow), 64'(m_ovf[0]));
      check({tag, "_busy"}, 64'(ia.o_busy), 64'(m_active[0]));
      check({tag, "_count"}, 64'(ia.o_word_count), 64'(m_cnt[0]));
      check({tag, "_pending"}, 64'(exp_qa.size()), 64'd0);
    end else begin
      check({tag, "_done"}, 64'(ib.o_done), 64'(m_done[1]));
      check({tag, "_ovf"}, 64'(ib.o_overflow), 64'(m_ovf[1]));
      check({tag, "_busy"}, 64'(ib.o_busy), 64'(m_active[1]));
      check({tag, "_count"}, 64'(ib.o_word_count), 64'(m_cnt[1]));
      check({tag, "_pending"}, 64'(exp_qb.size()), 64'd0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_a_we"}, 64'(ia.o_we), 64'd0);
    check({tag, "_a_addr"}, 64'(ia.o_addr), 64'd0);
    check({tag, "_a_data"}, 64'(ia.o_instr_data), 64'd0);
    check({tag, "_a_busy"}, 64'(ia.o_busy), 64'd0);
    check({tag, "_a_done"}, 64'(ia.o_done), 64'd0);
    check({tag, "_a_ovf"}, 64'(ia.o_overflow), 64'd0);
    check({tag, "_a_count"}, 64'(ia.o_word_count), 64'd0);
    check({tag, "_b_we"}, 64'(ib.o_we), 64'd0);
    check({tag, "_b_busy"}, 64'(ib.o_busy), 64'd0);
    check({tag, "_b_count"}, 64'(ib.o_word_count), 64'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_ld(input int id);
    if (id == 0) ia.i_start = 1'b1; else ib.i_start = 1'b1;
    model_start(id);
    tick();
    ia.i_start = 1'b0;
    ib.i_start = 1'b0;
  endtask

  task automatic send(input int id, input logic [7:0] b);
    if (id == 0) begin ia.i_rx_valid = 1'b1; ia.i_rx_data = b; end
    else begin ib.i_rx_valid = 1'b1; ib.i_rx_data = b; end
    model_byte(id, b);
    tick();
    ia.i_rx_valid = 1'b0;
    ib.i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input int id, input logic [31:0] w);
    for (int k = 0; k < 4; k++) send(id, w[31-8*k -: 8]);
  endtask

  function automatic logic [31:0] rand_non_halt();
    logic [31:0] w;
    w = $urandom();
    if (w == HALT) w = 32'h0;
    return w;
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] wd;
    int nw;
    ia.i_start = 1'b0; ia.i_rx_valid = 1'b0; ia.i_rx_data = '0;
    ib.i_start = 1'b0; ib.i_rx_valid = 1'b0; ib.i_rx_data = '0;
    model_reset(0);
    model_reset(1);
    idle(2);
    check_reset_vals("rst");
    rst_n = 1'b1;
    idle(1);

    // bytes before any start are ignored
    for (int i = 0; i < 6; i++) send(0, 8'($urandom_range(255, 0)));
    idle(2);
    check_status(0, "pre_start");

    // basic load with start and halt latency
    start_ld(0);
    check("start_busy", 64'(ia.o_busy), 64'd1);
    send_word(0, 32'h2008_0005);
    send_word(0, 32'h0000_0000);
    send_word(0, HALT);
    check("halt_we", 64'(ia.o_we), 64'd1);
    check("halt_data", 64'(ia.o_instr_data), 64'(HALT));
    check("halt_addr", 64'(ia.o_addr), 64'd8);
    tick();
    check("halt_done_lat", 64'(ia.o_done), 64'd1);
    check("halt_busy_lat", 64'(ia.o_busy), 64'd0);
    idle(2);
    check_status(0, "basic");

    // reload from DONE, back-to-back bytes, start ignored in RECV
    start_ld(0);
    check("reload_done_clr", 64'(ia.o_done), 64'd0);
    for (int i = 1; i <= 8; i++) send(0, 8'(i));
    idle(1);
    check("b2b_addr_hold", 64'(ia.o_addr), 64'd4);
    check("b2b_data_hold", 64'(ia.o_instr_data), 64'h0506_0708);
    send(0, 8'hA1);
    send(0, 8'hA2);
    start_ld(0);
    send(0, 8'hA3);
    send(0, 8'hA4);
    send_word(0, HALT);
    idle(3);
    check_status(0, "reload");

    // reset in the middle of a word
    start_ld(0);
    send(0, 8'h11);
    send(0, 8'h22);
    rst_n = 1'b0;
    model_reset(0);
    model_reset(1);
    tick();
    check_reset_vals("midrst");
    rst_n = 1'b1;
    idle(3);
    start_ld(0);
    send_word(0, HALT);
    idle(3);
    check_status(0, "after_rst");

    // small memory fills without halt
    start_ld(1);
    for (int w = 0; w < 4; w++) send_word(1, rand_non_halt());
    for (int i = 0; i < 4; i++) send(1, 8'($urandom_range(255, 0)));
    idle(3);
    check_status(1, "ovf_small");
    check("ovf_small_flag", 64'(ib.o_overflow), 64'd1);

    // default memory: 64th word at address 252 overflows
    start_ld(0);
    for (int w = 0; w < 65; w++) send_word(0, rand_non_halt());
    idle(3);
    check_status(0, "ovf64");
    check("ovf64_last_addr", 64'(ia.o_addr), 64'd252);

    // random sessions with occasional gaps and halts
    for (int s = 0; s < 4; s++) begin
      start_ld(0);
      nw = $urandom_range(70, 1);
      for (int w = 0; w < nw; w++) begin
        wd = ($urandom_range(9, 0) == 0) ? HALT : rand_non_halt();
        for (int k = 0; k < 4; k++) begin
          send(0, wd[31-8*k -: 8]);
          if ($urandom_range(3, 0) == 0) idle($urandom_range(2, 1));
        end
      end
      idle(3);
      check_status(0, $sformatf("rand%0d", s));
    end

    check("final_pending_a", 64'(exp_qa.size()), 64'd0);
    check("final_pending_b", 64'(exp_qb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instruction_loader.md
# instruction_loader

Writer side of the instruction-memory load path. Receives a byte stream (typically from the UART receiver) and packs every four bytes into a 32-bit instruction, MSB first. Each instruction is written into instruction memory through a single-cycle write strobe at consecutive addresses. Loading stops on the halt instruction or when memory is full, after which the fetch stage may run.

## Interface
Parameters:
- NB_DATA, 32 — instruction width in bits (byte count per word = NB_DATA/8 = 4)
- NB_ADDR, 8 — instruction-memory address width
- ADDR_STEP, 4 — address increment per word (byte addressing, matches PC+4)
- HALT_INSTR, 32'hFFFF_FFFF — word that terminates a load

Ports:
- clk  input  1  clock
- i_rst_n  input  1  reset, synchronous, active-low
- i_start  input  1  begin a load session (honoured only in IDLE or DONE)
- i_rx_data  input  8  received byte
- i_rx_valid  input  1  one-cycle strobe, i_rx_data valid
- o_we  output  1  memory write enable, one cycle per word
- o_addr  output  NB_ADDR  memory write address
- o_instr_data  output  NB_DATA  word to write
- o_busy  output  1  session in progress (RECV or WRITE)
- o_done  output  1  load finished, level, held until next i_start or reset
- o_overflow  output  1  memory filled without a halt word; valid while o_done=1
- o_word_count  output  NB_ADDR+1  words written this session, including the halt word

## Operation
- FSM states: IDLE, RECV, WRITE, DONE.
- IDLE: all bytes ignored. i_start → RECV, with o_addr=0, byte counter=0, o_word_count=0, o_overflow=0.
- RECV: each i_rx_valid shifts the byte in: word = {word[23:0], i_rx_data}. The first byte lands in [31:24]. On the 4th byte: → WRITE, with o_instr_data = the assembled word.
- WRITE: o_we=1 for exactly this cycle, with o_addr/o_instr_data stable. o_word_count increments. Next state:
  - word == HALT_INSTR → DONE, o_overflow=0.
  - else o_addr + ADDR_STEP would exceed 2^NB_ADDR−1 → DONE, o_overflow=1.
  - else o_addr += ADDR_STEP, byte counter=0 → RECV.
- Byte arriving during WRITE:
  - Accepted as byte 0 of the next word when the next state is RECV.
  - Dropped when the next state is DONE.
- DONE: o_done=1, bytes ignored, o_we=0. i_start → fresh session exactly as from IDLE, with o_done cleared the next cycle.
- i_start in RECV/WRITE is ignored.
- The partial word is discarded if reset occurs; no write is issued for it.
- o_busy = (state==RECV or WRITE).

## Timing
- Reset (synchronous, i_rst_n=0 at posedge): state IDLE. o_we=0, o_addr=0, o_instr_data=0, o_busy=0, o_done=0, o_overflow=0, o_word_count=0.
- All outputs are registered.
- i_start sampled at cycle N → o_busy=1 at N+1.
- 4th byte strobe at cycle N → o_we=1 at N+1 only. o_addr/o_instr_data are valid in N+1 and remain held until the next write.
- Halt or overflow write at cycle M → o_done=1 and o_busy=0 at M+1.
- Address wrap never occurs: with defaults, the last writable address is 252 (word 63). The 64th non-halt word sets o_overflow.
- Reset mid-session: after one reset cycle, outputs equal reset values and no o_we pulse is produced.
- Back-to-back strobes on consecutive cycles are supported with no byte lost, including across WRITE.

## Test plan
- Basic load: start, send bytes 20 08 00 05 | 00 00 00 00 | FF FF FF FF → three o_we pulses at addr 0, 4, 8 with data 32'h20080005, 32'h00000000, 32'hFFFFFFFF; then o_done=1, o_overflow=0, o_word_count=3.
- Byte order / back-to-back: 8 consecutive-cycle strobes 01 02 03 04 05 06 07 08 → writes 32'h01020304 @0 and 32'h05060708 @4. The 5th byte arrives in the WRITE cycle and is not lost.
- Overflow: NB_ADDR=4, ADDR_STEP=4, send 4 non-halt words → writes @0, 4, 8, 12; then o_done=1, o_overflow=1, o_word_count=4. Extra bytes produce no o_we.
- Ignored input:
  - Bytes before i_start produce no o_we.
  - i_start during RECV does not reset the address; load continues normally.
- Reset mid-word: send 2 bytes, pulse i_rst_n=0 → all outputs 0, no write. Restart and load 1 halt word → single write 32'hFFFFFFFF @0.
- Reload after DONE: i_start in DONE → o_done=0 next cycle; the new session writes from addr 0 and o_word_count restarts at 0.
